// File: rtl/lcd_pkg.sv
// Shared types and constants for the ST7789-class LCD frame sequencer.
//   state_t  : top-level sequencer states
//   phase_t  : byte-handshake sub-phase within a byte-issuing state
//   CMD_*    : panel command opcodes; COLMOD_16BPP selects RGB565
//   RED/GREEN/BLUE : RGB565 reference colours
//   *_FIRST/*_LAST : index ranges of the INIT and WINDOW lists in lcd_init_rom
// Optional feature macro: LCD_HW_RESET_EN (adds the HWRST state).
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef LCD_HW_RESET_EN
    ST_HWRST,
`endif
    ST_INIT,
    ST_WINDOW,
    ST_RAMWR,
    ST_PIXELS,
    ST_FIN
  } state_t;

  typedef enum logic [1:0] {
    PH_SEND,
    PH_WAIT,
    PH_DELAY
  } phase_t;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] COLMOD_16BPP = 8'h55;

  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] GREEN = 16'h07E0;
  localparam logic [15:0] BLUE  = 16'h001F;

  localparam int unsigned ROM_IDX_W = 4;
  localparam logic [ROM_IDX_W-1:0] INIT_FIRST = 4'd0;
  localparam logic [ROM_IDX_W-1:0] INIT_LAST  = 4'd4;
  localparam logic [ROM_IDX_W-1:0] WIN_FIRST  = 4'd5;
  localparam logic [ROM_IDX_W-1:0] WIN_LAST   = 4'd14;

endpackage

// File: rtl/lcd_init_rom.sv
// Combinational lookup of the INIT (indices 0..4) and WINDOW (5..14) byte lists.
//   idx         : list index
//   dc          : 0 = command byte, 1 = data byte
//   data        : byte to send
//   delay_after : sequencer must wait DELAY_CYCLES after this byte completes
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter int unsigned H_RES = 240,
  parameter int unsigned V_RES = 240
) (
  input  logic [ROM_IDX_W-1:0] idx,
  output logic                 dc,
  output logic [7:0]           data,
  output logic                 delay_after
);

  localparam logic [15:0] H_LAST = 16'(H_RES - 1);
  localparam logic [15:0] V_LAST = 16'(V_RES - 1);

  always_comb begin
    dc          = 1'b1;
    data        = '0;
    delay_after = 1'b0;
    case (idx)
      4'd0:  begin dc = 1'b0; data = CMD_SWRESET; delay_after = 1'b1; end
      4'd1:  begin dc = 1'b0; data = CMD_SLPOUT;  delay_after = 1'b1; end
      4'd2:  begin dc = 1'b0; data = CMD_COLMOD; end
      4'd3:  data = COLMOD_16BPP;
      4'd4:  begin dc = 1'b0; data = CMD_DISPON; end
      4'd5:  begin dc = 1'b0; data = CMD_CASET; end
      4'd6, 4'd7: data = 8'h00;
      4'd8:  data = H_LAST[15:8];
      4'd9:  data = H_LAST[7:0];
      4'd10: begin dc = 1'b0; data = CMD_RASET; end
      4'd11, 4'd12: data = 8'h00;
      4'd13: data = V_LAST[15:8];
      4'd14: data = V_LAST[7:0];
      default: dc = 1'b0;
    endcase
  end

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Byte source for spi_master: panel init, address window, then a two-colour frame
// (left half color_p1, right half color_p2), one byte per spi_start/spi_done handshake.
//   clk, rst_n          : clock, synchronous active-low reset
//   go                  : frame request, honoured only in IDLE
//   color_p1/color_p2   : RGB565 colours, latched when go is accepted
//   spi_start/spi_data  : byte launch pulse and byte (stable until spi_done)
//   spi_done            : byte complete from spi_master
//   lcd_dc              : 0 command / 1 data, valid with spi_data
//   lcd_rst_n           : panel hardware reset
//   busy, frame_done    : not-IDLE flag, end-of-frame pulse
// Macro LCD_HW_RESET_EN: adds a panel hardware-reset pulse before the first init.
module lcd_frame_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned H_RES        = 240,
  parameter int unsigned V_RES        = 240,
  parameter int unsigned DELAY_CYCLES = 1200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [15:0] color_p1,
  input  logic [15:0] color_p2,
  output logic        spi_start,
  output logic [7:0]  spi_data,
  input  logic        spi_done,
  output logic        lcd_dc,
  output logic        lcd_rst_n,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int unsigned DW = $clog2(DELAY_CYCLES + 1);
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [XW-1:0] X_HALF = XW'(H_RES / 2);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DELAY_CYCLES - 1);

  state_t               state, state_n;
  phase_t               phase, phase_n;
  logic [ROM_IDX_W-1:0] idx, idx_n;
  logic [XW-1:0]        x, x_n;
  logic [YW-1:0]        y, y_n;
  logic                 byte_sel, byte_sel_n;
  logic [DW-1:0]        dcnt, dcnt_n;
  logic [15:0]          p1, p1_n, p2, p2_n;
  logic                 init_ok, init_ok_n;
`ifdef LCD_HW_RESET_EN
  logic                 hw_hi, hw_hi_n;
`endif

  logic                 rom_dc, rom_delay;
  logic [7:0]           rom_byte;
  logic [15:0]          pix;

  lcd_init_rom #(.H_RES(H_RES), .V_RES(V_RES)) u_rom (
    .idx         (idx),
    .dc          (rom_dc),
    .data        (rom_byte),
    .delay_after (rom_delay)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      phase    <= PH_SEND;
      idx      <= '0;
      x        <= '0;
      y        <= '0;
      byte_sel <= 1'b0;
      dcnt     <= '0;
      p1       <= '0;
      p2       <= '0;
      init_ok  <= 1'b0;
`ifdef LCD_HW_RESET_EN
      hw_hi    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      idx      <= idx_n;
      x        <= x_n;
      y        <= y_n;
      byte_sel <= byte_sel_n;
      dcnt     <= dcnt_n;
      p1       <= p1_n;
      p2       <= p2_n;
      init_ok  <= init_ok_n;
`ifdef LCD_HW_RESET_EN
      hw_hi    <= hw_hi_n;
`endif
    end
  end

  // Outputs are decoded from registered state so spi_start appears the cycle
  // after go is accepted and spi_data stays put for the whole WAIT phase.
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    idx_n      = idx;
    x_n        = x;
    y_n        = y;
    byte_sel_n = byte_sel;
    dcnt_n     = dcnt;
    p1_n       = p1;
    p2_n       = p2;
    init_ok_n  = init_ok;
`ifdef LCD_HW_RESET_EN
    hw_hi_n    = hw_hi;
`endif
    spi_start  = 1'b0;
    spi_data   = '0;
    lcd_dc     = 1'b0;
    lcd_rst_n  = 1'b1;
    busy       = (state != ST_IDLE);
    frame_done = 1'b0;
    pix        = (x < X_HALF) ? p1 : p2;

    case (state)
      ST_IDLE: begin
        if (go) begin
          p1_n    = color_p1;
          p2_n    = color_p2;
          phase_n = PH_SEND;
          dcnt_n  = '0;
          if (init_ok) begin
            state_n = ST_WINDOW;
            idx_n   = WIN_FIRST;
          end else begin
            idx_n   = INIT_FIRST;
`ifdef LCD_HW_RESET_EN
            state_n = ST_HWRST;
            hw_hi_n = 1'b0;
`else
            state_n = ST_INIT;
`endif
          end
        end
      end

`ifdef LCD_HW_RESET_EN
      // Low for DELAY_CYCLES, then high for DELAY_CYCLES, then INIT.
      ST_HWRST: begin
        lcd_rst_n = hw_hi;
        if (dcnt == D_LAST) begin
          dcnt_n = '0;
          if (hw_hi) state_n = ST_INIT;
          else       hw_hi_n = 1'b1;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
`endif

      ST_INIT, ST_WINDOW, ST_RAMWR, ST_PIXELS: begin
        if (state == ST_PIXELS) begin
          spi_data = byte_sel ? pix[7:0] : pix[15:8];
          lcd_dc   = 1'b1;
        end else if (state == ST_RAMWR) begin
          spi_data = CMD_RAMWR;
        end else begin
          spi_data = rom_byte;
          lcd_dc   = rom_dc;
        end

        case (phase)
          PH_SEND: begin
            spi_start = 1'b1;
            phase_n   = PH_WAIT;
          end
          PH_WAIT: begin
            if (spi_done) begin
              phase_n = PH_SEND;
              case (state)
                ST_INIT: begin
                  // idx advances now; DELAY then falls straight into the next SEND.
                  idx_n = idx + 4'd1;
                  if (rom_delay) phase_n = PH_DELAY;
                  if (idx == INIT_LAST) begin
                    state_n   = ST_WINDOW;
                    init_ok_n = 1'b1;
                  end
                end
                ST_WINDOW: begin
                  idx_n = idx + 4'd1;
                  if (idx == WIN_LAST) state_n = ST_RAMWR;
                end
                ST_RAMWR: begin
                  state_n    = ST_PIXELS;
                  x_n        = '0;
                  y_n        = '0;
                  byte_sel_n = 1'b0;
                end
                default: begin
                  byte_sel_n = ~byte_sel;
                  if (byte_sel) begin
                    if (x == X_LAST) begin
                      x_n = '0;
                      if (y == Y_LAST) begin
                        y_n     = '0;
                        state_n = ST_FIN;
                      end else begin
                        y_n = y + YW'(1);
                      end
                    end else begin
                      x_n = x + XW'(1);
                    end
                  end
                end
              endcase
            end
          end
          default: begin
            if (dcnt == D_LAST) begin
              dcnt_n  = '0;
              phase_n = PH_SEND;
            end else begin
              dcnt_n = dcnt + DW'(1);
            end
          end
        endcase
      end

      ST_FIN: begin
        frame_done = 1'b1;
        state_n    = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Scoreboard bench for lcd_frame_sequencer (H_RES=4, V_RES=2, DELAY_CYCLES=10).
// An spi_master stand-in returns spi_done 8 cycles after each spi_start; expected
// bytes are queued when a frame is requested and popped on every observed spi_start.
module tb_lcd_frame_sequencer;

  localparam int unsigned H       = 4;
  localparam int unsigned V       = 2;
  localparam int unsigned D       = 10;
  localparam int unsigned SPI_LAT = 8;
  localparam int unsigned GAP     = SPI_LAT + 1;
  localparam int unsigned GAP_DLY = SPI_LAT + 1 + D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [15:0] color_p1 = '0;
  logic [15:0] color_p2 = '0;
  logic        spi_start;
  logic [7:0]  spi_data;
  logic        spi_done = 1'b0;
  logic        lcd_dc;
  logic        lcd_rst_n;
  logic        busy;
  logic        frame_done;

  always #5 clk = ~clk;

  lcd_frame_sequencer #(.H_RES(H), .V_RES(V), .DELAY_CYCLES(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .color_p1   (color_p1),
    .color_p2   (color_p2),
    .spi_start  (spi_start),
    .spi_data   (spi_data),
    .spi_done   (spi_done),
    .lcd_dc     (lcd_dc),
    .lcd_rst_n  (lcd_rst_n),
    .busy       (busy),
    .frame_done (frame_done)
  );

  typedef struct {
    logic        dc;
    logic [7:0]  data;
    int unsigned gap;   // cycles since previous spi_start; 0 = first byte, not checked
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned last_start = 0;
  int unsigned start_count = 0;
  int unsigned fd_count = 0;
  int unsigned spi_cnt = 0;
  bit          rst_low_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // spi_master stand-in plus output monitor, both on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      spi_cnt  = 0;
      spi_done = 1'b0;
    end else begin
      spi_done = 1'b0;
      if (spi_cnt != 0) begin
        spi_cnt--;
        if (spi_cnt == 0) spi_done = 1'b1;
      end
      if (spi_start) begin
        start_count++;
        check_eq("start_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("byte", spi_data, e.data);
          check_eq("dc", lcd_dc, e.dc);
          if (e.gap != 0) check_eq("gap", cyc - last_start, e.gap);
        end
        last_start = cyc;
        spi_cnt    = SPI_LAT;
      end
      if (frame_done) begin
        fd_count++;
        check_eq("fd_sb_empty", sb.size(), 0);
        check_eq("fd_latency", cyc - last_start, GAP);
      end
      if (!lcd_rst_n) rst_low_seen = 1'b1;
    end
  end

  task automatic push(input logic dc, input logic [7:0] b, input int unsigned gap);
    exp_t e;
    e.dc = dc; e.data = b; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic push_frame(input bit with_init, input logic [15:0] p1, input logic [15:0] p2);
    int unsigned g = 0;
    logic [15:0] c;
    if (with_init) begin
      push(1'b0, 8'h01, 0);
      push(1'b0, 8'h11, GAP_DLY);
      push(1'b0, 8'h3A, GAP_DLY);
      push(1'b1, 8'h55, GAP);
      push(1'b0, 8'h29, GAP);
      g = GAP;
    end
    push(1'b0, 8'h2A, g);
    push(1'b1, 8'h00, GAP); push(1'b1, 8'h00, GAP);
    push(1'b1, 8'h00, GAP); push(1'b1, 8'h03, GAP);
    push(1'b0, 8'h2B, GAP);
    push(1'b1, 8'h00, GAP); push(1'b1, 8'h00, GAP);
    push(1'b1, 8'h00, GAP); push(1'b1, 8'h01, GAP);
    push(1'b0, 8'h2C, GAP);
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++) begin
        c = (xx < H / 2) ? p1 : p2;
        push(1'b1, c[15:8], GAP);
        push(1'b1, c[7:0], GAP);
      end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_spi_start"}, spi_start, 0);
    check_eq({tag, "_spi_data"}, spi_data, 8'h00);
    check_eq({tag, "_lcd_dc"}, lcd_dc, 0);
    check_eq({tag, "_lcd_rst_n"}, lcd_rst_n, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_frame_done"}, frame_done, 0);
  endtask

  task automatic idle_quiet(input string tag, input int unsigned n);
    int unsigned s0 = start_count;
    repeat (n) tick();
    check_eq({tag, "_no_start"}, start_count, s0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check_idle("in_reset");
    sb.delete();
    rst_n = 1'b1;
  endtask

  task automatic start_frame(input logic [15:0] p1, input logic [15:0] p2, input bit with_init);
    push_frame(with_init, p1, p2);
    color_p1 = p1;
    color_p2 = p2;
    go = 1'b1;
    tick();
    go = 1'b0;
`ifdef LCD_HW_RESET_EN
    if (with_init) begin
      for (int i = 0; i < D; i++) begin
        check_eq("hwrst_low", {lcd_rst_n, spi_start}, 2'b00);
        tick();
      end
      for (int i = 0; i < D; i++) begin
        check_eq("hwrst_high", {lcd_rst_n, spi_start}, 2'b10);
        tick();
      end
    end
`endif
    check_eq("first_start", spi_start, 1);
    check_eq("busy_running", busy, 1);
  endtask

  task automatic wait_frame(input int unsigned n0, input bit disturb);
    int unsigned t = 0;
    while (fd_count == n0 && t < 3000) begin
      tick();
      t++;
      if (disturb && fd_count == n0) begin
        go = 1'($urandom_range(0, 1));
        color_p1 = 16'($urandom);
        color_p2 = 16'($urandom);
      end
    end
    go = 1'b0;
    check_eq("frame_done_seen", fd_count, n0 + 1);
  endtask

  task automatic wait_starts(input int unsigned target);
    int unsigned t = 0;
    while (start_count < target && t < 3000) begin
      tick();
      t++;
    end
    check_eq("starts_reached", 32'(start_count >= target), 1);
  endtask

  initial begin
    int unsigned s0;

    // 1: reset and quiet idle
    do_reset();
    tick();
    check_idle("after_reset");
    idle_quiet("idle", 20);

    // 2: full frame including init
    start_frame(16'hF800, 16'h001F, 1'b1);
    wait_frame(0, 1'b0);
    tick();
    check_idle("after_f1");
    idle_quiet("post_f1", 20);

    // 3: init skipped on second frame
    start_frame(16'h07E0, 16'h001F, 1'b0);
    wait_frame(1, 1'b0);
    idle_quiet("post_f2", 10);

    // 4: reset so init re-runs, then go/colour noise during the frame
    do_reset();
    start_frame(16'hF800, 16'h001F, 1'b1);
    wait_frame(2, 1'b1);
    idle_quiet("post_f3", 20);
    check_eq("fd_count_f3", fd_count, 3);

    // 5: reset in the middle of PIXELS, then a fresh frame restarts at 01
    s0 = start_count;
    start_frame(16'h07E0, 16'hF800, 1'b0);
    wait_starts(s0 + 13);
    rst_n = 1'b0;
    tick();
    check_idle("midframe_reset");
    tick();
    sb.delete();
    rst_n = 1'b1;
    idle_quiet("post_abort", 20);
    check_eq("fd_count_abort", fd_count, 3);
    start_frame(16'h001F, 16'h07E0, 1'b1);
    wait_frame(3, 1'b0);
    idle_quiet("post_f5", 10);

    check_eq("sb_drained", sb.size(), 0);
`ifndef LCD_HW_RESET_EN
    check_eq("lcd_rst_n_never_low", rst_low_seen, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
